// File: rtl/spram_req_ctrl.sv
// rtl/spram_req_ctrl.sv - single-port RAM request controller with registered RAM strobes
// Optional whole-RAM clear built when SPRAM_REQ_CTRL_CLEAR_EN is defined.
module spram_req_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              ram_en,
  output logic              ram_wr_rd,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RSP, CLEAR} state_t;

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

  state_t            state, state_nxt;
  logic              ready_q;
  logic [1:0]        lat_cnt, lat_cnt_nxt;
  logic              rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;
  logic              ram_en_nxt, ram_wr_rd_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [DATA_W-1:0] ram_din_nxt;

`ifdef SPRAM_REQ_CTRL_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
  assign clr_busy = (state == CLEAR);
`else
  logic clr_start_unused;
  assign clr_start_unused = clr_start;
  assign clr_busy         = 1'b0;
`endif

  // ready_q keeps req_ready low while reset is held and until the first edge after release
  assign req_ready = ready_q && (state == IDLE);

  always_comb begin
    state_nxt     = state;
    lat_cnt_nxt   = lat_cnt;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    ram_en_nxt    = 1'b0;
    ram_wr_rd_nxt = 1'b0;
    ram_addr_nxt  = '0;
    ram_din_nxt   = '0;
`ifdef SPRAM_REQ_CTRL_CLEAR_EN
    clr_addr_nxt  = clr_addr;
`endif
    case (state)
      IDLE: begin
`ifdef SPRAM_REQ_CTRL_CLEAR_EN
        if (clr_start) begin
          state_nxt     = CLEAR;
          clr_addr_nxt  = '0;
          ram_en_nxt    = 1'b1;
          ram_wr_rd_nxt = 1'b1;
        end else
`endif
        if (req_valid && req_ready) begin
          ram_en_nxt    = 1'b1;
          ram_wr_rd_nxt = req_wr;
          ram_addr_nxt  = req_addr;
          ram_din_nxt   = req_wdata;
          if (!req_wr) begin
            state_nxt   = RD_WAIT;
            lat_cnt_nxt = 2'd0;
          end
        end
      end
      RD_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          state_nxt     = RSP;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = ram_dout;
        end else begin
          lat_cnt_nxt = lat_cnt + 2'd1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
        end
      end
      CLEAR: begin
`ifdef SPRAM_REQ_CTRL_CLEAR_EN
        // clr_addr tracks the address on the bus; it wraps to 0 after the last write
        if (clr_addr == {ADDR_W{1'b1}}) begin
          state_nxt    = IDLE;
          clr_addr_nxt = '0;
        end else begin
          clr_addr_nxt  = clr_addr + ADDR_W'(1);
          ram_en_nxt    = 1'b1;
          ram_wr_rd_nxt = 1'b1;
          ram_addr_nxt  = clr_addr + ADDR_W'(1);
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ready_q   <= 1'b0;
      lat_cnt   <= 2'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ram_en    <= 1'b0;
      ram_wr_rd <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
`ifdef SPRAM_REQ_CTRL_CLEAR_EN
      clr_addr  <= '0;
`endif
    end else begin
      state     <= state_nxt;
      ready_q   <= 1'b1;
      lat_cnt   <= lat_cnt_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      ram_en    <= ram_en_nxt;
      ram_wr_rd <= ram_wr_rd_nxt;
      ram_addr  <= ram_addr_nxt;
      ram_din   <= ram_din_nxt;
`ifdef SPRAM_REQ_CTRL_CLEAR_EN
      clr_addr  <= clr_addr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_spram_req_ctrl.sv
// tb/tb_spram_req_ctrl.sv - scoreboard bench for spram_req_ctrl with a behavioural RAM
module tb_spram_req_ctrl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 4;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              clr_start, clr_busy;
  logic              ram_en, ram_wr_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } op_t;

  op_t               ram_q[$];
  logic [DATA_W-1:0] rsp_q[$];
  int                n_checks = 0;
  int                n_fail = 0;
  int                cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spram_req_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .ram_en(ram_en), .ram_wr_rd(ram_wr_rd), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // RAM model: synchronous write, RD_LAT-stage read pipeline
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe [0:RD_LAT-1];
  initial for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 4'hF;
  always @(posedge clk) begin
    if (ram_en && ram_wr_rd) mem[ram_addr] = ram_din;
    if (ram_en && !ram_wr_rd) rd_pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_dout = rd_pipe[RD_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    op_t e;
    if (ram_en) begin
      if (ram_q.size() == 0) check("ram_unexpected_strobe", 32'(ram_addr) | 32'h100, 32'h0);
      else begin
        e = ram_q.pop_front();
        check("ram_op", 32'({ram_wr_rd, ram_addr, ram_din}), 32'(e));
      end
    end else begin
      check("ram_idle_zero", 32'({ram_wr_rd, ram_addr, ram_din}), 32'h0);
    end
    if (rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) check("rsp_unexpected", 32'(rsp_rdata) | 32'h100, 32'h0);
      else check("rsp_rdata", 32'(rsp_rdata), 32'(rsp_q.pop_front()));
    end
  end

  task automatic wait_accept();
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 50) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    check("req_accepted", 32'(done), 32'h1);
  endtask

  task automatic send(input logic wr, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] exp_rd);
    op_t o;
    o.wr = wr; o.addr = addr; o.din = data;
    ram_q.push_back(o);
    if (!wr) rsp_q.push_back(exp_rd);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = data;
    wait_accept();
  endtask

  task automatic idle_req();
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic wait_rsp_valid();
    int n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rsp_valid_seen", 32'(rsp_valid), 32'h1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, n;
    op_t o;
    rst = 1'b1; rsp_ready = 1'b1; clr_start = 1'b0;
    idle_req();
    #1 rst = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    check("rst_clr_busy", 32'(clr_busy), 32'h0);
    check("rst_ram_bus", 32'({ram_en, ram_wr_rd, ram_addr, ram_din}), 32'h0);
    repeat (2) @(posedge clk);
    #1 check("rst_held_req_ready", 32'(req_ready), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_req_ready", 32'(req_ready), 32'h1);

    // write 0x1@0xAB, 0x2@0xBA, read 0xBA
    send(1'b1, 8'hAB, 4'h1, 4'h0);
    send(1'b1, 8'hBA, 4'h2, 4'h0);
    send(1'b0, 8'hBA, 4'h0, 4'h2);
    idle_req();
    check("rd_strobe", 32'({ram_en, ram_wr_rd}), 32'h2);
    @(posedge clk); #1;
    check("rd_rsp_not_yet", 32'(rsp_valid), 32'h0);
    check("rd_wait_not_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    check("rd_rsp_at_e2", 32'(rsp_valid), 32'h1);
    check("rd_rsp_data", 32'(rsp_rdata), 32'h2);
    @(posedge clk); #1;
    check("rd_rsp_done", 32'(rsp_valid), 32'h0);
    check("rd_back_idle", 32'(req_ready), 32'h1);

    // backpressure on read of 0xAB
    rsp_ready = 1'b0;
    send(1'b0, 8'hAB, 4'h0, 4'h1);
    idle_req();
    wait_rsp_valid();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp_rsp_rdata", 32'(rsp_rdata), 32'h1);
      check("bp_req_ready", 32'(req_ready), 32'h0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_after_ready", 32'(req_ready), 32'h1);
    check("bp_rsp_dropped", 32'(rsp_valid), 32'h0);

    // four back-to-back writes
    send(1'b1, 8'h00, 4'h3, 4'h0);
    c0 = cyc;
    send(1'b1, 8'h01, 4'h5, 4'h0);
    send(1'b1, 8'h02, 4'h9, 4'h0);
    send(1'b1, 8'h03, 4'hC, 4'h0);
    idle_req();
    check("burst_span", 32'(cyc - c0), 32'h3);
    @(posedge clk); #1;

    // reset while a response is pending
    rsp_ready = 1'b0;
    send(1'b0, 8'h02, 4'h0, 4'h9);
    idle_req();
    wait_rsp_valid();
    check("rsp_before_reset", 32'(rsp_rdata), 32'h9);
    rst = 1'b0;
    #1;
    check("rsp_reset_valid", 32'(rsp_valid), 32'h0);
    check("rsp_reset_rdata", 32'(rsp_rdata), 32'h0);
    check("rsp_reset_ready", 32'(req_ready), 32'h0);
    rsp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rsp_reset_recover", 32'(req_ready), 32'h1);

`ifdef SPRAM_REQ_CTRL_CLEAR_EN
    // clear wins over a simultaneous read
    for (int i = 0; i < 256; i++) begin
      o.wr = 1'b1; o.addr = 8'(i); o.din = 4'h0;
      ram_q.push_back(o);
    end
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'hAB; req_wdata = 4'h0;
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    check("clr_entry_busy", 32'(clr_busy), 32'h1);
    check("clr_entry_ready", 32'(req_ready), 32'h0);
    n = 1;
    while (clr_busy && n < 300) begin
      @(posedge clk); #1;
      if (clr_busy) n++;
      if (n == 128) check("clr_mid_ready", 32'(req_ready), 32'h0);
    end
    check("clr_busy_cycles", 32'(n), 32'd256);
    send(1'b0, 8'hAB, 4'h0, 4'h0);
    idle_req();
    wait_rsp_valid();
    @(posedge clk); #1;
    send(1'b1, 8'h63, 4'h7, 4'h0);
    send(1'b1, 8'h64, 4'h7, 4'h0);
    idle_req();

    // reset at clear cycle 100
    for (int i = 0; i < 100; i++) begin
      o.wr = 1'b1; o.addr = 8'(i); o.din = 4'h0;
      ram_q.push_back(o);
    end
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("clr_rst_busy", 32'(clr_busy), 32'h0);
    check("clr_rst_ram_en", 32'(ram_en), 32'h0);
    check("clr_rst_pending_ops", 32'(ram_q.size()), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 8'h63, 4'h0, 4'h0);
    idle_req();
    wait_rsp_valid();
    @(posedge clk); #1;
    send(1'b0, 8'h64, 4'h0, 4'h7);
    idle_req();
    wait_rsp_valid();
    @(posedge clk); #1;
`else
    // clr_start has no effect and no priority
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("noclr_busy", 32'(clr_busy), 32'h0);
      check("noclr_ram_en", 32'(ram_en), 32'h0);
      check("noclr_ready", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
    end
    clr_start = 1'b1;
    send(1'b1, 8'h10, 4'h6, 4'h0);
    clr_start = 1'b0;
    idle_req();
    check("noclr_write_strobe", 32'({ram_en, ram_wr_rd, ram_addr}), 32'h310);
    send(1'b0, 8'h10, 4'h0, 4'h6);
    idle_req();
    wait_rsp_valid();
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("ram_q_drained", 32'(ram_q.size()), 32'h0);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spram_req_ctrl.md
SPRAM_REQ_CTRL -- requirements
Module: spram_req_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the RAM address width.
REQ-002 Parameter DATA_W, default 4, SHALL set the RAM data width.
REQ-003 Parameter RD_LAT, default 1, range 1..3, SHALL set the cycles from RAM read strobe to valid ram_dout.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 rst  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 req_valid  in  1  SHALL flag a pending request.
REQ-007 req_ready  out  1  SHALL flag that a request can be accepted.
REQ-008 req_wr  in  1  SHALL select the request type: 1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_W  SHALL carry the request address.
REQ-010 req_wdata  in  DATA_W  SHALL carry the write data.
REQ-011 rsp_valid  out  1  SHALL flag valid read data.
REQ-012 rsp_ready  in  1  SHALL flag that the consumer takes the response.
REQ-013 rsp_rdata  out  DATA_W  SHALL carry the read data.
REQ-014 clr_start  in  1  SHALL request a clear of the whole RAM.
REQ-015 clr_busy  out  1  SHALL flag that a clear is in progress.
REQ-016 ram_en, ram_wr_rd  out  1 each  SHALL be the RAM strobe and direction (ram_wr_rd: 1 = write).
REQ-017 ram_addr  out  ADDR_W; ram_din  out  DATA_W  SHALL carry the RAM address and write data.
REQ-018 ram_dout  in  DATA_W  SHALL carry the RAM read data.

Function
REQ-019 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-020 Every RAM output SHALL be registered.
- For a request accepted at edge E: ram_en = 1 for exactly the one cycle after E, with ram_wr_rd, ram_addr and ram_din holding that request's values.
REQ-021 FSM states SHALL be IDLE, RD_WAIT, RSP and CLEAR.
- req_ready = 1 only in IDLE.
REQ-022 Write accepted: the block SHALL stay in IDLE.
- One write per cycle back-to-back.
- No response generated.
REQ-023 Read accepted: IDLE -> RD_WAIT.
- At edge E+1+RD_LAT: sample ram_dout into rsp_rdata, set rsp_valid = 1, go to RSP.
REQ-024 In RSP, rsp_valid and rsp_rdata SHALL hold stable until an edge with rsp_ready = 1.
- At that edge: rsp_valid -> 0, state -> IDLE.
- Next request accepted no earlier than the following cycle.
REQ-025 When ram_en = 0, ram_wr_rd, ram_addr and ram_din SHALL be 0.
REQ-026 clr_start = 1 at an IDLE edge SHALL enter CLEAR.
- clr_start has priority over a simultaneous req_valid; that request is not accepted.
- clr_start is ignored outside IDLE.
REQ-027 In CLEAR the block SHALL write 0 to addresses 0 .. 2^ADDR_W-1 in ascending order, one per cycle.
- ram_en = 1, ram_wr_rd = 1 throughout.
- clr_busy = 1 for exactly 2^ADDR_W cycles.
- After the write to the last address: return to IDLE; address counter wraps to 0 with no extra write.
REQ-028 clr_busy SHALL equal (state == CLEAR).

Reset
REQ-029 rst = 0 SHALL immediately force, regardless of clk:
- state IDLE
- req_ready = 0 while asserted, 1 from the first edge after release
- rsp_valid, rsp_rdata, clr_busy, ram_en, ram_wr_rd, ram_addr, ram_din = 0
REQ-030 Reset during RD_WAIT, RSP or CLEAR SHALL abort the operation.
- Pending response dropped; clear not resumed.

Configuration
REQ-031 With macro SPRAM_REQ_CTRL_CLEAR_EN defined, the CLEAR state and address counter SHALL be built as specified.
REQ-032 Without SPRAM_REQ_CTRL_CLEAR_EN:
- CLEAR logic omitted.
- clr_start ignored; clr_busy tied to 0.
- Requests arbitrate without clr_start priority.

Verification
REQ-033 Write then read: write 0x1 to 0xAB, write 0x2 to 0xBA, read 0xBA.
- Expect ram_en pulses with ram_wr_rd = 1, 1, 0.
- Expect rsp_rdata = 0x2, rsp_valid rising at read accept edge + 2 (RD_LAT = 1).
REQ-034 Backpressure: read 0xAB (holds 0x1) with rsp_ready = 0 for 5 cycles.
- Expect rsp_valid = 1 and rsp_rdata = 0x1 stable for those 5 cycles, req_ready = 0.
- Expect IDLE one edge after rsp_ready = 1.
REQ-035 Back-to-back writes: 4 writes on consecutive cycles to 0x00..0x03.
- Expect 4 consecutive ram_en cycles with addresses 0x00..0x03.
REQ-036 Clear (macro defined): clr_start and req_valid asserted together in IDLE.
- Expect clr_busy high for 256 cycles, request held off.
- A subsequent read of 0xAB returns 0x0.
REQ-037 Reset mid-clear: rst = 0 at clear cycle 100.
- Expect clr_busy = 0 and ram_en = 0 immediately, no further RAM writes.
- Expect address 0x64 not written; address 0x63 written.
REQ-038 Macro undefined: pulse clr_start.
- Expect clr_busy = 0, no ram_en, req_ready = 1 throughout.
